// File: rtl/voice_alloc_pkg.sv
// Shared types and constants for the voice allocator: FSM states, per-voice table entry,
// and the candidate classes used while scanning for a target voice.
package voice_alloc_pkg;

    localparam int AGE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2
    } va_state_t;

    typedef struct packed {
        logic [7:0]       key;
        logic [AGE_W-1:0] age;
    } voice_entry_t;

    // Lower code = higher priority. CLS_NONE marks a voice that cannot serve the event.
    localparam logic [2:0] CLS_MATCH = 3'd0;
    localparam logic [2:0] CLS_FREE  = 3'd1;
    localparam logic [2:0] CLS_REL   = 3'd2;
    localparam logic [2:0] CLS_HELD  = 3'd3;
    localparam logic [2:0] CLS_NONE  = 3'd4;

    function automatic int clogb2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/voice_alloc_if.sv
// Event channel into the allocator plus the note bus it drives toward the synth engine.
interface voice_alloc_if
    import voice_alloc_pkg::*;
#(
    parameter int VOICES  = 32,
    parameter int V_WIDTH = clogb2(VOICES)
);
    // Handshake: an event transfers on a rising edge where ev_valid and ev_ready are both 1;
    // ev_is_on/ev_key/ev_vel must be stable while ev_valid is high.
    logic               ev_valid;
    logic               ev_ready;
    logic               ev_is_on;
    logic [7:0]         ev_key;
    logic [7:0]         ev_vel;

    logic [VOICES-1:0]  keys_on;
    logic               note_on;
    logic               note_off;
    logic               steal;
    logic               off_note_error;
    logic [V_WIDTH-1:0] cur_key_adr;
    logic [7:0]         cur_key_val;
    logic [7:0]         cur_vel_on;
    logic [7:0]         cur_vel_off;
    logic [V_WIDTH:0]   active_keys;

    modport master (
        output ev_valid, ev_is_on, ev_key, ev_vel,
        input  ev_ready, keys_on, note_on, note_off, steal, off_note_error,
        input  cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off, active_keys
    );

    modport slave (
        input  ev_valid, ev_is_on, ev_key, ev_vel,
        output ev_ready, keys_on, note_on, note_off, steal, off_note_error,
        output cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off, active_keys
    );

endinterface

// File: rtl/va_cand_cmp.sv
// Picks the better of the running best candidate and the voice currently being scanned.
// Only released/held classes compare on age; otherwise the earlier (lower) index is kept.
module va_cand_cmp
    import voice_alloc_pkg::*;
#(
    parameter int V_WIDTH = 5
) (
    input  logic [2:0]         best_cls,
    input  logic [AGE_W-1:0]   best_age,
    input  logic [V_WIDTH-1:0] best_idx,
    input  logic [2:0]         cand_cls,
    input  logic [AGE_W-1:0]   cand_age,
    input  logic [V_WIDTH-1:0] cand_idx,
    output logic [2:0]         win_cls,
    output logic [AGE_W-1:0]   win_age,
    output logic [V_WIDTH-1:0] win_idx
);

    logic take;

    always_comb begin
        take = 1'b0;
        if (cand_cls < best_cls) begin
            take = 1'b1;
        end else if ((cand_cls == best_cls) &&
                     ((cand_cls == CLS_REL) || (cand_cls == CLS_HELD)) &&
                     (cand_age > best_age)) begin
            take = 1'b1;
        end
        win_cls = take ? cand_cls : best_cls;
        win_age = take ? cand_age : best_age;
        win_idx = take ? cand_idx : best_idx;
    end

endmodule

// File: rtl/voice_allocator.sv
// Maps note on/off events onto voice slots (retrigger, free, oldest released, oldest held)
// by scanning one voice per cycle, then issues a single strobe on the engine note bus.
module voice_allocator
    import voice_alloc_pkg::*;
#(
    parameter int VOICES  = 32,
    parameter int V_WIDTH = clogb2(VOICES)
) (
    input  logic              data_clk,
    input  logic              reset,
    input  logic              panic,
    input  logic [VOICES-1:0] voice_free,
    voice_alloc_if.slave      bus,
    output va_state_t         dbg_state
);

    va_state_t          state_q, state_d;
    voice_entry_t       table_q [VOICES];
    logic [V_WIDTH-1:0] scan_idx;
    logic               lat_on;
    logic [7:0]         lat_key, lat_vel;

    logic [2:0]         best_cls, cand_cls, win_cls;
    logic [AGE_W-1:0]   best_age, win_age;
    logic [V_WIDTH-1:0] best_idx, win_idx;
    logic               last_scan;

    logic [VOICES-1:0]  keys_q;
    logic               note_on_q, note_off_q, steal_q, err_q;
    logic [V_WIDTH-1:0] adr_q;
    logic [7:0]         key_val_q, vel_on_q, vel_off_q;
    logic [V_WIDTH:0]   active_q, pop;

    assign last_scan = (state_q == SCAN) && (scan_idx == V_WIDTH'(VOICES - 1));

    // voice_free is looked at live, only for the voice under the scan pointer.
    always_comb begin
        cand_cls = CLS_HELD;
        if (keys_q[scan_idx] && (table_q[scan_idx].key == lat_key)) cand_cls = CLS_MATCH;
        else if (!lat_on)                                          cand_cls = CLS_NONE;
        else if (voice_free[scan_idx])                             cand_cls = CLS_FREE;
        else if (!keys_q[scan_idx])                                cand_cls = CLS_REL;
    end

    va_cand_cmp #(.V_WIDTH(V_WIDTH)) u_cmp (
        .best_cls (best_cls),
        .best_age (best_age),
        .best_idx (best_idx),
        .cand_cls (cand_cls),
        .cand_age (table_q[scan_idx].age),
        .cand_idx (scan_idx),
        .win_cls  (win_cls),
        .win_age  (win_age),
        .win_idx  (win_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.ev_valid) state_d = SCAN;
            SCAN:    if (last_scan)    state_d = ISSUE;
            ISSUE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (panic) state_d = IDLE;
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < VOICES; i++) pop = pop + (V_WIDTH + 1)'(keys_q[i]);
    end

    always_ff @(posedge data_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            scan_idx   <= '0;
            lat_on     <= 1'b0;
            lat_key    <= '0;
            lat_vel    <= '0;
            best_cls   <= CLS_NONE;
            best_age   <= '0;
            best_idx   <= '0;
            keys_q     <= '0;
            note_on_q  <= 1'b0;
            note_off_q <= 1'b0;
            steal_q    <= 1'b0;
            err_q      <= 1'b0;
            adr_q      <= '0;
            key_val_q  <= '0;
            vel_on_q   <= '0;
            vel_off_q  <= '0;
            active_q   <= '0;
            for (int i = 0; i < VOICES; i++) table_q[i] <= '{key: 8'd0, age: '1};
        end else begin
            state_q    <= state_d;
            note_on_q  <= 1'b0;
            note_off_q <= 1'b0;
            steal_q    <= 1'b0;
            err_q      <= 1'b0;
            active_q   <= pop;
            if (panic) begin
                keys_q <= '0;
                for (int i = 0; i < VOICES; i++) table_q[i].key <= 8'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.ev_valid) begin
                            lat_on   <= bus.ev_is_on;
                            lat_key  <= bus.ev_key;
                            lat_vel  <= bus.ev_vel;
                            scan_idx <= '0;
                            best_cls <= CLS_NONE;
                            best_age <= '0;
                            best_idx <= '0;
                        end
                    end
                    SCAN: begin
                        scan_idx <= scan_idx + 1'b1;
                        best_cls <= win_cls;
                        best_age <= win_age;
                        best_idx <= win_idx;
                        // The final comparison result is committed straight away so the
                        // strobes are already visible during ISSUE.
                        if (last_scan) begin
                            if (lat_on) begin
                                keys_q[win_idx] <= 1'b1;
                                for (int i = 0; i < VOICES; i++) begin
                                    if (V_WIDTH'(i) == win_idx) begin
                                        table_q[i].key <= lat_key;
                                        table_q[i].age <= '0;
                                    end else if (table_q[i].age != '1) begin
                                        table_q[i].age <= table_q[i].age + 1'b1;
                                    end
                                end
                                note_on_q <= 1'b1;
                                steal_q   <= (win_cls == CLS_HELD);
                                adr_q     <= win_idx;
                                key_val_q <= lat_key;
                                vel_on_q  <= lat_vel;
                            end else if (win_cls == CLS_MATCH) begin
                                keys_q[win_idx] <= 1'b0;
                                note_off_q      <= 1'b1;
                                adr_q           <= win_idx;
                                key_val_q       <= lat_key;
                                vel_off_q       <= lat_vel;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.ev_ready       = (state_q == IDLE);
    assign bus.keys_on        = keys_q;
    assign bus.note_on        = note_on_q;
    assign bus.note_off       = note_off_q;
    assign bus.steal          = steal_q;
    assign bus.off_note_error = err_q;
    assign bus.cur_key_adr    = adr_q;
    assign bus.cur_key_val    = key_val_q;
    assign bus.cur_vel_on     = vel_on_q;
    assign bus.cur_vel_off    = vel_off_q;
    assign bus.active_keys    = active_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for a 4-voice allocator: stimulus pushes hand-computed strobe expectations,
// a monitor compares them whenever the note bus shows a strobe.
module tb_voice_allocator;
    import voice_alloc_pkg::*;

    localparam logic [2:0] K_ON  = 3'b100;
    localparam logic [2:0] K_OFF = 3'b010;
    localparam logic [2:0] K_ERR = 3'b001;

    typedef struct packed {
        logic [2:0] strobes;
        logic       steal;
        logic [1:0] adr;
        logic [7:0] key;
        logic [7:0] von;
        logic [7:0] voff;
        logic [3:0] keys;
        logic [2:0] act;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic       data_clk;
    logic       reset;
    logic       panic;
    logic [3:0] voice_free;
    va_state_t  dbg_state;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] m_adr;
    logic [7:0] m_key, m_von, m_voff;

    voice_alloc_if #(.VOICES(4), .V_WIDTH(2)) bus ();

    voice_allocator #(.VOICES(4), .V_WIDTH(2)) dut (
        .data_clk   (data_clk),
        .reset      (reset),
        .panic      (panic),
        .voice_free (voice_free),
        .bus        (bus.slave),
        .dbg_state  (dbg_state)
    );

    initial begin
        data_clk = 1'b0;
        forever #5 data_clk = ~data_clk;
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endfunction

    task automatic do_reset();
        @(negedge data_clk);
        reset = 1'b1;
        repeat (2) @(negedge data_clk);
        reset = 1'b0;
        m_adr = '0; m_key = '0; m_von = '0; m_voff = '0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.ev_ready !== 1'b1 && n < 50) begin
            @(negedge data_clk);
            n++;
        end
        check({"ev_ready_", tag}, bus.ev_ready, 1'b1);
    endtask

    task automatic send(input logic on, input logic [7:0] key, input logic [7:0] vel,
                        input logic [2:0] kind, input logic [1:0] adr, input logic stl,
                        input logic [3:0] keys);
        exp_t e;
        @(negedge data_clk);
        wait_ready("pre");
        if (kind == K_ON)  begin m_adr = adr; m_key = key; m_von  = vel; end
        if (kind == K_OFF) begin m_adr = adr; m_key = key; m_voff = vel; end
        e = '{strobes: kind, steal: stl, adr: m_adr, key: m_key, von: m_von, voff: m_voff,
              keys: keys, act: 3'($countones(keys))};
        exp_q.push_back(W'(e));
        bus.ev_valid = 1'b1;
        bus.ev_is_on = on;
        bus.ev_key   = key;
        bus.ev_vel   = vel;
        @(negedge data_clk);
        bus.ev_valid = 1'b0;
        repeat (2) @(negedge data_clk);
        wait_ready("done");
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge data_clk);
            if ((bus.note_on | bus.note_off | bus.off_note_error | bus.steal) === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe",
                          {bus.note_on, bus.note_off, bus.off_note_error, bus.steal}, 0);
                end else begin
                    e = exp_t'(exp_q.pop_front());
                    check("strobes", {bus.note_on, bus.note_off, bus.off_note_error}, e.strobes);
                    check("steal", bus.steal, e.steal);
                    check("cur_key_adr", bus.cur_key_adr, e.adr);
                    check("cur_key_val", bus.cur_key_val, e.key);
                    check("cur_vel_on", bus.cur_vel_on, e.von);
                    check("cur_vel_off", bus.cur_vel_off, e.voff);
                    check("keys_on", bus.keys_on, e.keys);
                    @(negedge data_clk);
                    check("active_keys", bus.active_keys, e.act);
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        panic = 1'b0;
        voice_free = 4'b1111;
        bus.ev_valid = 1'b0;
        bus.ev_is_on = 1'b0;
        bus.ev_key   = '0;
        bus.ev_vel   = '0;
        do_reset();

        check("rst_keys_on", bus.keys_on, 4'b0000);
        check("rst_active", bus.active_keys, 0);
        check("rst_ev_ready", bus.ev_ready, 1'b1);
        check("rst_strobes", {bus.note_on, bus.note_off, bus.off_note_error, bus.steal}, 0);
        check("rst_cur", {bus.cur_key_adr, bus.cur_key_val, bus.cur_vel_on, bus.cur_vel_off}, 0);
        check("rst_state", dbg_state, IDLE);

        // First note lands on voice 0, then the same key retriggers it.
        send(1'b1, 8'd60, 8'd100, K_ON, 2'd0, 1'b0, 4'b0001);
        voice_free = 4'b1110;
        send(1'b1, 8'd60, 8'd90, K_ON, 2'd0, 1'b0, 4'b0001);

        // Fill, release voice 1, reuse it, then steal the oldest held voice.
        do_reset();
        voice_free = 4'b1111;
        send(1'b1, 8'd60, 8'd10, K_ON, 2'd0, 1'b0, 4'b0001); voice_free = 4'b1110;
        send(1'b1, 8'd62, 8'd11, K_ON, 2'd1, 1'b0, 4'b0011); voice_free = 4'b1100;
        send(1'b1, 8'd64, 8'd12, K_ON, 2'd2, 1'b0, 4'b0111); voice_free = 4'b1000;
        send(1'b1, 8'd65, 8'd13, K_ON, 2'd3, 1'b0, 4'b1111); voice_free = 4'b0000;
        send(1'b0, 8'd62, 8'd20, K_OFF, 2'd1, 1'b0, 4'b1101);
        send(1'b1, 8'd67, 8'd21, K_ON, 2'd1, 1'b0, 4'b1111);
        send(1'b1, 8'd69, 8'd22, K_ON, 2'd0, 1'b1, 4'b1111);
        send(1'b0, 8'd70, 8'd30, K_ERR, 2'd0, 1'b0, 4'b1111);

        // Panic two cycles into SCAN drops the event.
        @(negedge data_clk);
        bus.ev_valid = 1'b1; bus.ev_is_on = 1'b1; bus.ev_key = 8'd71; bus.ev_vel = 8'd40;
        @(negedge data_clk);
        bus.ev_valid = 1'b0;
        @(negedge data_clk);
        panic = 1'b1;
        @(negedge data_clk);
        panic = 1'b0;
        check("panic_keys_on", bus.keys_on, 4'b0000);
        check("panic_ev_ready", bus.ev_ready, 1'b1);
        check("panic_state", dbg_state, IDLE);
        voice_free = 4'b1111;
        repeat (8) @(negedge data_clk);
        check("panic_no_pending", exp_q.size(), 0);
        send(1'b0, 8'd69, 8'd31, K_ERR, 2'd0, 1'b0, 4'b0000);

        // Ages: voices 0/1 start saturated, voice 3 starts young; after 300 retriggers of
        // voice 2 all three must read 255, so the oldest-released tie goes to voice 0.
        do_reset();
        voice_free = 4'b1000;
        send(1'b1, 8'd60, 8'd1, K_ON, 2'd3, 1'b0, 4'b1000); voice_free = 4'b0100;
        send(1'b1, 8'd62, 8'd2, K_ON, 2'd2, 1'b0, 4'b1100); voice_free = 4'b0000;
        for (int i = 0; i < 300; i++) send(1'b1, 8'd62, 8'd3, K_ON, 2'd2, 1'b0, 4'b1100);
        send(1'b0, 8'd60, 8'd4, K_OFF, 2'd3, 1'b0, 4'b0100);
        send(1'b1, 8'd70, 8'd5, K_ON, 2'd0, 1'b0, 4'b0101);

        repeat (4) @(negedge data_clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
